uart_tx: RTL and testbench

- 8N1 UART transmitter: one start bit, 8 data bits LSB first, no parity, one stop bit.
- Serialises a parallel byte onto `sout` at a rate of one bit per `CLKS_PER_BIT` clock cycles.
- Sits between a host-side byte producer and the board TX pin.
- `busy_tx` tells the producer when a frame is in flight.

---
 rtl/uart_tx.sv | 129 ++++++++++++
 tb/tb_uart_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (start bit, 8 data bits LSB first, stop bit).
// Each serial bit is held for CLKS_PER_BIT clock cycles. sout and busy_tx
// come straight from flops, so no input reaches an output combinationally.
module uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       fpga_clk,
    input  logic       nrst,
    input  logic       tx_en,
    input  logic [7:0] din,
    output logic       sout,
    output logic       busy_tx
);

    // A single-cycle bit period still needs a one-bit counter.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;

    logic             bit_done;

    assign bit_done = (cnt_q == CNT_MAX);
    assign sout     = sout_q;
    assign busy_tx  = busy_q;

    // State register; reset aborts any frame in flight and returns the line high.
    always_ff @(posedge fpga_clk or posedge nrst) begin
        if (nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: the registered sout/busy values are computed one edge
    // ahead, so the line level changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        sout_d  = sout_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                sout_d = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (tx_en) begin
                    // din is captured only here; later changes do not affect the frame.
                    shreg_d = din;
                    state_d = START;
                    sout_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                    sout_d  = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        sout_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        sout_d = shreg_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    // Always pass through IDLE for one cycle, giving the minimum inter-frame gap.
                    cnt_d   = '0;
                    state_d = IDLE;
                    sout_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                sout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed/randomised stimulus for uart_tx, checked every cycle
// against a frame-level reference model holding the expected line/busy levels.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       fpga_clk = 1'b0;
    logic       nrst;
    logic       tx_en;
    logic [7:0] din;
    logic       sout;
    logic       busy_tx;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_run = 0;

    // Upcoming {sout, busy_tx} values, one entry per clock edge.
    logic [1:0] exp_q[$];

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .fpga_clk(fpga_clk),
        .nrst    (nrst),
        .tx_en   (tx_en),
        .din     (din),
        .sout    (sout),
        .busy_tx (busy_tx)
    );

    always #5 fpga_clk = ~fpga_clk;

    // A frame is ten bit periods of busy line followed by one mandatory idle cycle.
    task automatic push_frame(input logic [7:0] d);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < CPB; k++)
                exp_q.push_back({bits[i], 1'b1});
        exp_q.push_back(2'b10);
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] req);
        n_cmp++;
        assert (obs === req)
        else begin
            n_bad++;
            $error("FAIL %s: observed {sout,busy}=%b required %b at %0t", tag, obs, req, $time);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step(input string tag);
        logic       en_s;
        logic [7:0] d_s;
        logic [1:0] req;
        en_s = tx_en;
        d_s  = din;
        @(posedge fpga_clk);
        if (nrst) begin
            exp_q.delete();
            req = 2'b10;
        end else begin
            if (exp_q.size() == 0 && en_s)
                push_frame(d_s);
            req = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b10;
        end
        #1;
        check(tag, {sout, busy_tx}, req);
        if (nrst) begin
            busy_run = 0;
        end else if (busy_tx === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            n_cmp++;
            assert (busy_run == 10 * CPB)
            else begin
                n_bad++;
                $error("FAIL busy_len: observed %0d cycles required %0d", busy_run, 10 * CPB);
            end
            busy_run = 0;
        end
    endtask

    initial begin
        nrst  = 1'b1;
        tx_en = 1'b0;
        din   = 8'h00;

        // Reset held, with tx_en toggling: nothing may start.
        step("reset");
        tx_en = 1'b1; din = 8'hA5;
        step("reset_en");
        tx_en = 1'b0;
        step("reset");
        tx_en = 1'b1;
        step("reset_en");

        // Continuous enable with 0xEE: two back-to-back frames, drop enable mid-second-frame.
        nrst  = 1'b0;
        din   = 8'hEE;
        repeat (60) step("frame_ee");
        tx_en = 1'b0;
        din   = 8'($urandom);
        repeat (40) step("frame_ee_tail");

        // Frame 0x95 after 100 ns idle; din scrambled mid-frame.
        repeat (10) step("idle");
        tx_en = 1'b1; din = 8'h95;
        step("frame_95");
        tx_en = 1'b0;
        din = 8'($urandom);
        repeat (20) step("frame_95");
        din = 8'($urandom);
        repeat (25) step("frame_95");

        // Frame 0xF0, then the line must sit idle high.
        tx_en = 1'b1; din = 8'hF0;
        step("frame_f0");
        tx_en = 1'b0;
        repeat (50) step("frame_f0");

        // Random enable and data, changing every cycle.
        for (int i = 0; i < 400; i++) begin
            tx_en = ($urandom_range(0, 3) != 0);
            din   = 8'($urandom);
            step("random");
        end
        tx_en = 1'b0;
        repeat (45) step("random_drain");

        // Asynchronous reset in the middle of the data bits.
        tx_en = 1'b1; din = 8'($urandom);
        step("pre_abort");
        tx_en = 1'b0;
        repeat (CPB * 3) step("pre_abort");
        #2;
        nrst = 1'b1;
        #1;
        check("async_rst", {sout, busy_tx}, 2'b10);
        exp_q.delete();
        busy_run = 0;
        step("rst_hold");
        step("rst_hold");

        // Fresh frame after release, with a full start bit.
        nrst  = 1'b0;
        tx_en = 1'b1;
        din   = 8'($urandom);
        repeat (45) step("after_rst");
        tx_en = 1'b0;
        repeat (10) step("after_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
